// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and feeds the IF/ID register.
// Latency: a word accepted on edge N is presented in IF/ID after edge N (1 instruction/cycle with ready high).
// Backpressure: stall_id holds IF/ID; a word arriving during a stall is parked in a one-entry buffer and requests pause.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall_id            ID does not consume IF/ID this cycle
//   redirect/redirect_pc taken branch/jump from EX/MEM and its target (low 2 bits ignored)
//   imem_req/imem_addr  fetch request and word-aligned fetch address (= PC)
//   imem_ready/imem_data memory returns imem_data this cycle
//   instruction/pc_plus4/valid_id  IF/ID pipeline register
//   fetch_count/stall_count        performance counters, present only with IF_PERF_CNT_EN defined
//
// Optional feature macro: IF_PERF_CNT_EN

module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_id,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   output logic [31:0] instruction,
   output logic [31:0] pc_plus4,
   output logic        valid_id
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   typedef enum logic {
      FETCH    = 1'b0,
      BUFFERED = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] buf_instr;
   logic [31:0] buf_pc4;

   // Only bits [31:2] of the redirect target are meaningful.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign pc_next   = pc + 32'd4;   // 32-bit modulo wrap is intended
   assign imem_addr = {pc[31:2], 2'b00};

   // Gated by the reset input itself so the request is low during the reset
   // cycle regardless of whatever state the register held before it.
   assign imem_req  = (state == FETCH) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= {RESET_PC[31:2], 2'b00};
         instruction <= NOP_INSTR;
         pc_plus4    <= 32'h0000_0000;
         valid_id    <= 1'b0;
         buf_instr   <= NOP_INSTR;
         buf_pc4     <= 32'h0000_0000;
`ifdef IF_PERF_CNT_EN
         fetch_count <= 32'h0000_0000;
         stall_count <= 32'h0000_0000;
`endif
      end else begin
`ifdef IF_PERF_CNT_EN
         // Transfers landing in a redirect cycle are thrown away, so not counted.
         if (imem_req && imem_ready && !redirect && fetch_count != 32'hFFFF_FFFF)
            fetch_count <= fetch_count + 32'd1;
         if (stall_id && valid_id && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
`endif
         if (redirect) begin
            // Squash: drop IF/ID, the parked word and any data returned now.
            // A pending request is simply abandoned by moving the address.
            state       <= FETCH;
            pc          <= {redirect_pc[31:2], 2'b00};
            instruction <= NOP_INSTR;
            valid_id    <= 1'b0;
            buf_instr   <= NOP_INSTR;
            buf_pc4     <= 32'h0000_0000;
         end else begin
            case (state)
               FETCH: begin
                  if (imem_ready) begin
                     pc <= pc_next;
                     if (!stall_id) begin
                        instruction <= imem_data;
                        pc_plus4    <= pc_next;
                        valid_id    <= 1'b1;
                     end else begin
                        // ID is stalled: park the word and stop requesting.
                        buf_instr <= imem_data;
                        buf_pc4   <= pc_next;
                        state     <= BUFFERED;
                     end
                  end else if (!stall_id) begin
                     // Memory not ready: ID consumed the old entry, insert a bubble.
                     // pc_plus4 is left as is so the bubble carries no new PC.
                     instruction <= NOP_INSTR;
                     valid_id    <= 1'b0;
                  end
               end
               BUFFERED: begin
                  if (!stall_id) begin
                     instruction <= buf_instr;
                     pc_plus4    <= buf_pc4;
                     valid_id    <= 1'b1;
                     state       <= FETCH;
                  end
               end
               default: state <= FETCH;
            endcase
         end
      end
   end

endmodule
